// File: rtl/act_quant_unit_if.sv
// Row stream bundle for act_quant_unit: accumulator rows in, int8 rows plus
// UB write address out. The slave modport is the quantizer side.
interface act_quant_unit_if #(
    parameter int LANES     = 16,
    parameter int ACC_BITS  = 20,
    parameter int OUT_BITS  = 8,
    parameter int ADDR_BITS = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*ACC_BITS-1:0]     in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*OUT_BITS-1:0]     out_data;
    logic [ADDR_BITS-1:0]          out_addr;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/act_quant_unit.sv
// act_quant_unit: post-accumulator requantization stage.
// Per lane: scale multiply -> rounding arithmetic right shift -> optional
// ReLU + int8 saturation, 3 register stages sharing one stall signal.
// A job-level FSM counts input rows and pulses done once the pipe drains.
// Optional build macro ACT_QUANT_SAT_CNT_EN adds the sat_count port.

// One lane of the datapath; stage registers advance together on adv.
module act_quant_lane #(
    parameter int ACC_BITS = 20,
    parameter int OUT_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       adv,
    input  logic signed [ACC_BITS-1:0] acc,
    input  logic [7:0]                 scale,
    input  logic [4:0]                 shift,
    input  logic                       relu_en,
    output logic [OUT_BITS-1:0]        q
`ifdef ACT_QUANT_SAT_CNT_EN
    ,
    output logic                       clip
`endif
);
    localparam int PW = ACC_BITS + 9;   // product width
    localparam int RW = PW + 1;         // rounding headroom
    localparam logic signed [RW-1:0] ONE  = 1;
    localparam logic signed [RW-1:0] QMAX = (ONE <<< (OUT_BITS - 1)) - ONE;
    localparam logic signed [RW-1:0] QMIN = -(ONE <<< (OUT_BITS - 1));

    logic signed [PW-1:0] p_q;
    logic signed [RW-1:0] pe, r_d, r_q, v;
    logic [OUT_BITS-1:0]  q_d;

    // Stage 1: signed accumulator times zero-extended unsigned scale.
    always_ff @(posedge clk) begin
        if (reset)    p_q <= '0;
        else if (adv) p_q <= PW'(acc) * PW'($signed({1'b0, scale}));
    end

    // Stage 2 rounding: add half an LSB then arithmetic shift (rounds half
    // toward +inf). Shifts of PW or more always round to zero for any
    // product, so they short-circuit and keep the math inside RW bits.
    always_comb begin
        pe  = RW'(p_q);
        r_d = pe;
        if (shift != 5'd0) begin
            if (int'(shift) >= PW) r_d = '0;
            else                   r_d = (pe + (ONE <<< (shift - 5'd1))) >>> shift;
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (reset)    r_q <= '0;
        else if (adv) r_q <= r_d;
    end

    // Stage 3 combinational: ReLU then saturate to the signed output range.
    always_comb begin
        v   = (relu_en && (r_q < 0)) ? '0 : r_q;
        q_d = v[OUT_BITS-1:0];
        if (v > QMAX)      q_d = QMAX[OUT_BITS-1:0];
        else if (v < QMIN) q_d = QMIN[OUT_BITS-1:0];
    end

`ifdef ACT_QUANT_SAT_CNT_EN
    // ReLU output is 0, so only genuine range clipping is flagged here.
    assign clip = (v > QMAX) || (v < QMIN);
`endif

    // Stage 3 register drives out_data directly.
    always_ff @(posedge clk) begin
        if (reset)    q <= '0;
        else if (adv) q <= q_d;
    end
endmodule

module act_quant_unit #(
    parameter int LANES     = 16,
    parameter int ACC_BITS  = 20,
    parameter int OUT_BITS  = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   beat_count,
    input  logic [7:0]           scale,
    input  logic [4:0]           shift,
    input  logic                 relu_en,
    act_quant_unit_if.slave      bus,
    output logic                 busy,
    output logic                 done
`ifdef ACT_QUANT_SAT_CNT_EN
    ,
    output logic [15:0]          sat_count
`endif
);
    localparam int STAGES = 3;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                          state, state_nx;
    logic                            start_q, start_go;
    logic [ADDR_BITS:0]              bc_q, acc_cnt;
    logic [7:0]                      scale_q;
    logic [4:0]                      shift_q;
    logic                            relu_q;
    logic [STAGES:1]                 vld_pipe;
    logic                            adv, in_fire, out_fire;
    logic [LANES-1:0][OUT_BITS-1:0]  q_row;

    assign adv      = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready = (state == RUN) && (acc_cnt < bc_q) && adv;
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = vld_pipe[STAGES] && bus.out_ready;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_data  = q_row;

    // A start is only taken in IDLE with no start already pending.
    assign start_go = start && (state == IDLE) && !start_q;
    assign busy     = start_q || (state != IDLE);
    assign done     = (state == FIN);

    // Start is registered: cfg and counters load on the start edge, the FSM
    // leaves IDLE one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b0;
            bc_q    <= '0;
            scale_q <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else begin
            start_q <= start_go;
            if (start_go) begin
                bc_q    <= beat_count;
                scale_q <= scale;
                shift_q <= shift;
                relu_q  <= relu_en;
            end
        end
    end

    // Input row counter and output address.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt      <= '0;
            bus.out_addr <= '0;
        end else begin
            if (start_go)     acc_cnt <= '0;
            else if (in_fire) acc_cnt <= acc_cnt + 1'b1;
            if (start_go)      bus.out_addr <= base_addr;
            else if (out_fire) bus.out_addr <= bus.out_addr + 1'b1;
        end
    end

    // Stage valid shift register, held as a whole when stalled.
    always_ff @(posedge clk) begin
        if (reset)    vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next state: RUN exits when all rows are in and the pipe will be
    // empty after this edge (nothing in stages 1-2, stage 3 empty or leaving).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_q) state_nx = (bc_q == '0) ? FIN : RUN;
            RUN:  if ((acc_cnt == bc_q) && !vld_pipe[1] && !vld_pipe[2] && adv)
                      state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef ACT_QUANT_SAT_CNT_EN
    logic [LANES-1:0]             clip;
    logic [$clog2(LANES+1)-1:0]   n_clip;
    logic [16:0]                  sat_sum;

    // Clipped-lane population count for the row leaving stage 2.
    always_comb begin
        n_clip = '0;
        for (int i = 0; i < LANES; i++)
            n_clip = n_clip + $bits(n_clip)'(clip[i]);
        sat_sum = {1'b0, sat_count} + 17'(n_clip);
    end

    // Saturating counter, only for rows that actually advance into stage 3.
    always_ff @(posedge clk) begin
        if (reset || start_go)
            sat_count <= '0;
        else if (vld_pipe[2] && adv)
            sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        act_quant_lane #(
            .ACC_BITS (ACC_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .adv     (adv),
            .acc     (bus.in_data[i*ACC_BITS +: ACC_BITS]),
            .scale   (scale_q),
            .shift   (shift_q),
            .relu_en (relu_q),
            .q       (q_row[i])
`ifdef ACT_QUANT_SAT_CNT_EN
            ,
            .clip    (clip[i])
`endif
        );
    end
endmodule

// File: tb/tb_act_quant_unit.sv
// Directed bench for act_quant_unit: a vector table of single-row jobs plus
// hand sequences for backpressure, address wrap, reset abort, empty job and
// ignored start.
module tb_act_quant_unit;
    localparam int NV = 8;

    logic        clk = 1'b0;
    logic        reset, start, relu_en;
    logic [7:0]  base_addr, scale;
    logic [8:0]  beat_count;
    logic [4:0]  shift;
    logic        busy, done;
`ifdef ACT_QUANT_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    act_quant_unit_if bus();

    act_quant_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .beat_count (beat_count),
        .scale      (scale),
        .shift      (shift),
        .relu_en    (relu_en),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
`ifdef ACT_QUANT_SAT_CNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk_i(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0]        scale;
        logic [4:0]        shift;
        logic              relu;
        logic [15:0][19:0] acc;
        logic [15:0][7:0]  exp;
        logic [15:0]       sat;
    } vec_t;

    vec_t vecs [NV];

    logic [319:0] rows[$];
    logic [127:0] got_data[$];
    logic [7:0]   got_addr[$];
    int           got_cyc[$];
    int           acc_cyc[$];
    int           done_cnt, done_cyc, start_cyc, stable_err, ir_drop;
    bit           timeout, busy_at1;

    function automatic logic [319:0] mk_row(input int r);
        logic [15:0][19:0] a;
        for (int l = 0; l < 16; l++) a[l] = 20'(r * 10 + l);
        return a;
    endfunction

    function automatic logic [127:0] mk_exp(input int r);
        logic [15:0][7:0] e;
        for (int l = 0; l < 16; l++) e[l] = 8'(r * 10 + l);
        return e;
    endfunction

    // One job: start pulse on iteration 0, optional stray start later,
    // rows fed as fast as in_ready allows, out_ready held low for `stall`
    // cycles after the first out_valid. Runs a few cycles past done.
    task automatic run_job(input logic [7:0] b, input logic [8:0] bc, input logic [7:0] sc,
                           input logic [4:0] sh, input logic rl, input int stall,
                           input int alt_start_at);
        int idx = 0, hold = 0, k = 0, tail = 0;
        bit seen = 0, prev_stall = 0;
        logic [127:0] prev_data = '0;
        logic [7:0]   prev_addr = '0;
        got_data.delete(); got_addr.delete(); got_cyc.delete(); acc_cyc.delete();
        done_cnt = 0; done_cyc = -1; stable_err = 0; ir_drop = 0; timeout = 0; busy_at1 = 0;
        forever begin
            @(negedge clk);
            start = (k == 0) || (k == alt_start_at);
            if (k == 0) begin
                base_addr = b; beat_count = bc; scale = sc; shift = sh; relu_en = rl;
                start_cyc = cyc;
            end else if (k == alt_start_at) begin
                base_addr = 8'hA5; beat_count = 9'd7; scale = 8'd0; shift = 5'd3; relu_en = 1'b1;
            end
            bus.in_valid = (idx < rows.size());
            bus.in_data  = (idx < rows.size()) ? rows[idx] : '0;
            #1;
            if (bus.out_valid && !seen) begin seen = 1; hold = stall; end
            bus.out_ready = (hold == 0);
            if (bus.out_valid && hold > 0) hold--;
            #1;
            if (k == 1) busy_at1 = busy;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_addr !== prev_addr))
                stable_err++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_addr  = bus.out_addr;
            if (idx > 0 && idx < rows.size() && !bus.in_ready) ir_drop++;
            if (bus.in_valid && bus.in_ready) begin acc_cyc.push_back(cyc); idx++; end
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_addr.push_back(bus.out_addr);
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
            end
            k++;
            if (done_cnt > 0) tail++;
            if (tail == 4) break;
            if (k >= 200) begin timeout = 1; break; end
        end
        start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        chk_i("job_timeout", int'(timeout), 0);
    endtask

    initial begin
        // Vector table: single-row jobs with hand-computed lane results.
        for (int i = 0; i < NV; i++) vecs[i] = '0;
        // saturation, no ReLU
        vecs[0].scale = 8'd1; vecs[0].shift = 5'd0; vecs[0].relu = 1'b0; vecs[0].sat = 16'd2;
        vecs[0].acc[0] = 20'd100; vecs[0].acc[1] = -20'sd100; vecs[0].acc[2] = 20'd200; vecs[0].acc[3] = -20'sd300;
        vecs[0].exp[0] = 8'h64; vecs[0].exp[1] = 8'h9C; vecs[0].exp[2] = 8'h7F; vecs[0].exp[3] = 8'h80;
        // round half up, no ReLU: 15->4, -15->-4, 6->2
        vecs[1].scale = 8'd3; vecs[1].shift = 5'd2; vecs[1].relu = 1'b0;
        vecs[1].acc[0] = 20'd5; vecs[1].acc[1] = -20'sd5; vecs[1].acc[2] = 20'd2;
        vecs[1].exp[0] = 8'h04; vecs[1].exp[1] = 8'hFC; vecs[1].exp[2] = 8'h02;
        // same with ReLU
        vecs[2].scale = 8'd3; vecs[2].shift = 5'd2; vecs[2].relu = 1'b1;
        vecs[2].acc[0] = 20'd5; vecs[2].acc[1] = -20'sd5; vecs[2].acc[2] = 20'd2;
        vecs[2].exp[0] = 8'h04; vecs[2].exp[1] = 8'h00; vecs[2].exp[2] = 8'h02;
        // max scale, shift 8, accumulator extremes
        vecs[3].scale = 8'd255; vecs[3].shift = 5'd8; vecs[3].relu = 1'b0; vecs[3].sat = 16'd3;
        vecs[3].acc[0] = 20'd128; vecs[3].acc[1] = -20'sd129; vecs[3].acc[2] = 20'd1;
        vecs[3].acc[3] = -20'sd1; vecs[3].acc[4] = 20'h7FFFF; vecs[3].acc[5] = 20'h80000;
        vecs[3].exp[0] = 8'h7F; vecs[3].exp[1] = 8'h80; vecs[3].exp[2] = 8'h01;
        vecs[3].exp[3] = 8'hFF; vecs[3].exp[4] = 8'h7F; vecs[3].exp[5] = 8'h80;
        // shift 1 half-way cases
        vecs[4].scale = 8'd1; vecs[4].shift = 5'd1; vecs[4].relu = 1'b0;
        vecs[4].acc[0] = 20'd3; vecs[4].acc[1] = -20'sd3; vecs[4].acc[2] = 20'd1;
        vecs[4].acc[3] = -20'sd1; vecs[4].acc[4] = -20'sd2;
        vecs[4].exp[0] = 8'h02; vecs[4].exp[1] = 8'hFF; vecs[4].exp[2] = 8'h01;
        vecs[4].exp[3] = 8'h00; vecs[4].exp[4] = 8'hFF;
        // ReLU clamp is not a saturation
        vecs[5].scale = 8'd1; vecs[5].shift = 5'd0; vecs[5].relu = 1'b1; vecs[5].sat = 16'd1;
        vecs[5].acc[0] = -20'sd300; vecs[5].acc[1] = 20'd300; vecs[5].acc[2] = -20'sd1;
        vecs[5].exp[0] = 8'h00; vecs[5].exp[1] = 8'h7F; vecs[5].exp[2] = 8'h00;
        // shift 20: extremes land just inside range
        vecs[6].scale = 8'd255; vecs[6].shift = 5'd20; vecs[6].relu = 1'b0;
        vecs[6].acc[0] = 20'h7FFFF; vecs[6].acc[1] = 20'h80000;
        vecs[6].exp[0] = 8'h7F; vecs[6].exp[1] = 8'h81;
        // shift 31: everything rounds to zero
        vecs[7].scale = 8'd255; vecs[7].shift = 5'd31; vecs[7].relu = 1'b0;
        vecs[7].acc[0] = 20'h7FFFF; vecs[7].acc[1] = 20'h80000;

        reset = 1'b1; start = 1'b0; relu_en = 1'b0; base_addr = '0; beat_count = '0;
        scale = '0; shift = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_i("rst_in_ready",  int'(bus.in_ready), 0);
        chk_i("rst_out_valid", int'(bus.out_valid), 0);
        chk_d("rst_out_data",  bus.out_data, '0);
        chk_i("rst_out_addr",  int'(bus.out_addr), 0);
        chk_i("rst_busy",      int'(busy), 0);
        chk_i("rst_done",      int'(done), 0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            rows.delete();
            rows.push_back(vecs[i].acc);
            run_job(8'h40 + 8'(i), 9'd1, vecs[i].scale, vecs[i].shift, vecs[i].relu, 0, -1);
            chk_i($sformatf("v%0d_rows", i), got_data.size(), 1);
            if (got_data.size() == 1 && acc_cyc.size() == 1) begin
                chk_d($sformatf("v%0d_data", i), got_data[0], vecs[i].exp);
                chk_i($sformatf("v%0d_addr", i), int'(got_addr[0]), 8'h40 + i);
                chk_i($sformatf("v%0d_latency", i), got_cyc[0] - acc_cyc[0], 3);
                chk_i($sformatf("v%0d_done_time", i), done_cyc - got_cyc[0], 1);
            end
            chk_i($sformatf("v%0d_done_cnt", i), done_cnt, 1);
`ifdef ACT_QUANT_SAT_CNT_EN
            chk_i($sformatf("v%0d_sat_count", i), int'(sat_count), int'(vecs[i].sat));
`endif
        end

        // Backpressure: 5 stall cycles after the first out_valid.
        rows.delete();
        for (int r = 0; r < 4; r++) rows.push_back(mk_row(r));
        run_job(8'h10, 9'd4, 8'd1, 5'd0, 1'b0, 5, -1);
        chk_i("bp_rows", got_data.size(), 4);
        for (int r = 0; r < 4 && r < got_data.size(); r++) begin
            chk_d($sformatf("bp_data%0d", r), got_data[r], mk_exp(r));
            chk_i($sformatf("bp_addr%0d", r), int'(got_addr[r]), 8'h10 + r);
        end
        chk_i("bp_stable", stable_err, 0);
        chk_i("bp_in_ready_drop", int'(ir_drop > 0), 1);
        chk_i("bp_done_cnt", done_cnt, 1);

        // Address wrap past 255.
        run_job(8'd254, 9'd4, 8'd1, 5'd0, 1'b0, 0, -1);
        chk_i("wrap_rows", got_data.size(), 4);
        if (got_addr.size() == 4) begin
            chk_i("wrap_addr0", int'(got_addr[0]), 254);
            chk_i("wrap_addr1", int'(got_addr[1]), 255);
            chk_i("wrap_addr2", int'(got_addr[2]), 0);
            chk_i("wrap_addr3", int'(got_addr[3]), 1);
        end
        chk_i("wrap_done_cnt", done_cnt, 1);

        // Reset after 2 of 4 rows accepted.
        begin
            int n = 0, g = 0, dn = 0, ov = 0;
            @(negedge clk);
            start = 1'b1; base_addr = 8'h20; beat_count = 9'd4; scale = 8'd1; shift = 5'd0; relu_en = 1'b0;
            @(negedge clk);
            start = 1'b0;
            while (n < 2 && g < 20) begin
                bus.in_valid = 1'b1;
                bus.in_data  = mk_row(n);
                #1;
                if (bus.in_ready) n++;
                @(negedge clk);
                g++;
            end
            chk_i("abort_accepted", n, 2);
            bus.in_valid = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk_i("abort_out_valid", int'(bus.out_valid), 0);
            chk_i("abort_busy", int'(busy), 0);
            chk_i("abort_in_ready", int'(bus.in_ready), 0);
            repeat (8) begin
                if (done) dn++;
                if (bus.out_valid) ov++;
                @(negedge clk);
            end
            chk_i("abort_no_done", dn, 0);
            chk_i("abort_no_output", ov, 0);
        end
        rows.delete();
        rows.push_back(mk_row(7));
        run_job(8'h30, 9'd1, 8'd1, 5'd0, 1'b0, 0, -1);
        chk_i("post_abort_rows", got_data.size(), 1);
        if (got_data.size() == 1) begin
            chk_d("post_abort_data", got_data[0], mk_exp(7));
            chk_i("post_abort_addr", int'(got_addr[0]), 8'h30);
        end
        chk_i("post_abort_done_cnt", done_cnt, 1);

        // Empty job.
        rows.delete();
        run_job(8'h00, 9'd0, 8'd1, 5'd0, 1'b0, 0, -1);
        chk_i("empty_rows", got_data.size(), 0);
        chk_i("empty_done_time", done_cyc - start_cyc, 2);
        chk_i("empty_done_cnt", done_cnt, 1);
        chk_i("empty_busy", int'(busy_at1), 1);

        // Stray start during RUN carries different cfg and must be ignored.
        for (int r = 0; r < 3; r++) rows.push_back(mk_row(r + 2));
        run_job(8'h50, 9'd3, 8'd2, 5'd1, 1'b0, 0, 4);
        chk_i("ign_rows", got_data.size(), 3);
        for (int r = 0; r < 3 && r < got_data.size(); r++) begin
            chk_d($sformatf("ign_data%0d", r), got_data[r], mk_exp(r + 2));
            chk_i($sformatf("ign_addr%0d", r), int'(got_addr[r]), 8'h50 + r);
        end
        chk_i("ign_done_cnt", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
